// File: rtl/seg_scan_mux3_if.sv
// seg_scan_mux3_if: bus bundle between a pattern source and the seg_scan_mux3 display scanner.
//
// Signals:
//   load        1      single-cycle strobe capturing seg0_in..seg2_in into the pending buffer
//   seg0_in     [0:6]  digit 0 pattern, abcdefg with bit 0 = a, active-low segments
//   seg1_in     [0:6]  digit 1 pattern
//   seg2_in     [0:6]  digit 2 pattern
//   blank       1      level, forces the segments off while high (scan keeps running)
//   blink       1      (only with SEG_SCAN_BLINK_EN) enables frame-rate blinking
//   seg_out     [0:6]  registered shared segment bus, active-low
//   an_n        [2:0]  registered digit enables, active-low, one-hot-low
//   frame_done  1      one-cycle pulse at each frame boundary
//
// Modports: master drives the patterns/controls, slave is the scanner.
// Optional feature macro: SEG_SCAN_BLINK_EN.

interface seg_scan_mux3_if;
    logic       load;
    logic [0:6] seg0_in;
    logic [0:6] seg1_in;
    logic [0:6] seg2_in;
    logic       blank;
`ifdef SEG_SCAN_BLINK_EN
    logic       blink;
`endif
    logic [0:6] seg_out;
    logic [2:0] an_n;
    logic       frame_done;

    modport master (
        output load, seg0_in, seg1_in, seg2_in, blank,
`ifdef SEG_SCAN_BLINK_EN
        output blink,
`endif
        input  seg_out, an_n, frame_done
    );

    modport slave (
        input  load, seg0_in, seg1_in, seg2_in, blank,
`ifdef SEG_SCAN_BLINK_EN
        input  blink,
`endif
        output seg_out, an_n, frame_done
    );
endinterface

// File: rtl/seg_scan_mux3.sv
// seg_scan_mux3: time-multiplexes three active-low 7-segment patterns onto one shared segment bus
// with three active-low digit enables. Patterns are double-buffered: a load fills the pending
// buffer and the active buffer is only replaced at a frame boundary, so a digit never changes
// while it is being scanned. The first GUARD cycles of every digit slot are blanked to prevent
// ghosting between digits.
//
// Parameters:
//   DIV_COUNT     clk cycles per digit slot (2 .. 2**DIV_W-1)
//   DIV_W         prescaler width
//   GUARD         blanked cycles at the start of each slot (< DIV_COUNT)
//   BLINK_FRAMES  (only with SEG_SCAN_BLINK_EN) frames per blink phase
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_mux3_if.slave: load, seg0_in..seg2_in, blank, [blink] in;
//          seg_out, an_n, frame_done out
//
// Optional feature macro: SEG_SCAN_BLINK_EN adds the blink input and the frame-based blink phase.

module seg_scan_mux3 #(
    parameter int unsigned DIV_COUNT    = 50000,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned GUARD        = 4
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 32
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_mux3_if.slave bus
);

    localparam logic [DIV_W-1:0] DivLast  = DIV_W'(DIV_COUNT - 1);
    localparam logic [DIV_W-1:0] GuardLen = DIV_W'(GUARD);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  guard_q, guard_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0][0:6]   act_q, act_d;
    logic [2:0][0:6]   pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [0:6]        seg_q, seg_d;
    logic [2:0]        an_q, an_d;
    logic              bnd_q, bnd_d;
    logic              done_q, done_d;

    logic              tick;
    logic              boundary;
    logic              guard_run;
    logic              blink_off;
    logic [0:6]        cur_pat;

    assign tick      = (div_q == DivLast);
    assign boundary  = tick && (idx_q == 2'd2);
    // guard_q saturates at GUARD, so it is below GUARD only in the first GUARD cycles of a slot
    assign guard_run = (guard_q < GuardLen);

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FrmLast = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (!bus.blink) begin
            frm_d   = '0;
            phase_d = 1'b0;
        end else if (boundary) begin
            if (frm_q == FrmLast) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = bus.blink && phase_q;
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        unique case (idx_q)
            2'd0:    cur_pat = act_q[0];
            2'd1:    cur_pat = act_q[1];
            2'd2:    cur_pat = act_q[2];
            default: cur_pat = '1;
        endcase
    end

    always_comb begin
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        idx_d        = idx_q;
        guard_d      = guard_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (tick) begin
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            guard_d = '0;
        end else if (guard_run) begin
            guard_d = guard_q + DIV_W'(1);
        end

        // Boundary first: a same-cycle load must land in pending, not in active
        if (boundary) begin
            if (pend_valid_q) begin
                act_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end
        if (bus.load) begin
            pend_d       = {bus.seg2_in, bus.seg1_in, bus.seg0_in};
            pend_valid_d = 1'b1;
        end

        unique case (idx_q)
            2'd0:    an_d = 3'b110;
            2'd1:    an_d = 3'b101;
            2'd2:    an_d = 3'b011;
            default: an_d = 3'b111;
        endcase

        seg_d  = (bus.blank || guard_run || blink_off) ? '1 : cur_pat;
        bnd_d  = boundary;
        // Delayed one more cycle so the pulse lines up with the first registered digit-0 output
        done_d = bnd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            guard_q      <= '0;
            idx_q        <= 2'd0;
            act_q        <= '1;
            pend_q       <= '1;
            pend_valid_q <= 1'b0;
            seg_q        <= '1;
            an_q         <= 3'b111;
            bnd_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            div_q        <= div_d;
            guard_q      <= guard_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            bnd_q        <= bnd_d;
            done_q       <= done_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_mux3.sv
// tb_seg_scan_mux3: scoreboard bench for seg_scan_mux3 (DIV_COUNT=8, GUARD=2).
// A timeline model pushes the expected registered outputs at every clock edge; a monitor pops
// and compares on the falling edge. Stimulus mixes directed scenarios with random traffic.

module tb_seg_scan_mux3;
    localparam int DIV = 8;
    localparam int GRD = 2;
    localparam int FR  = 3 * DIV;

    typedef struct packed {
        logic [0:6] seg;
        logic [2:0] an;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seg_scan_mux3_if bus ();

    seg_scan_mux3 #(
        .DIV_COUNT (DIV),
        .DIV_W     (16),
        .GUARD     (GRD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: p = cycles since reset release, disp = pattern shown this frame,
    // land = frame number -> pattern that frame starts showing (last load wins).
    int              p = 0;
    logic [2:0][0:6] disp = '1;
    logic [2:0][0:6] land [int];
    exp_t            q [$];

    initial begin
        forever begin
            int   f, s, pos;
            exp_t e;
            @(posedge clk);
            if (!rst_n) begin
                p    = 0;
                disp = '1;
                land.delete();
                e    = '{seg: 7'h7f, an: 3'b111, done: 1'b0};
                q.push_back(e);
            end else begin
                f   = p / FR;
                s   = (p % FR) / DIV;
                pos = p % DIV;
                if ((p % FR == 0) && land.exists(f)) disp = land[f];
                e.an   = ~(3'b001 << s);
                e.done = (p % FR == 0) && (p != 0);
                e.seg  = (bus.blank || pos < GRD) ? 7'h7f : disp[s];
                q.push_back(e);
                if (bus.load) begin
                    checks++;
                    if ($isunknown({bus.seg0_in, bus.seg1_in, bus.seg2_in})) begin
                        errors++;
                        $display("FAIL x_in: seg inputs %b %b %b, required known 0/1 with load=1",
                                 bus.seg0_in, bus.seg1_in, bus.seg2_in);
                    end
                    // A load on the final cycle of a frame collides with the boundary and
                    // therefore lands one frame later
                    land[(p + 1) / FR + 1] = {bus.seg2_in, bus.seg1_in, bus.seg0_in};
                end
                p++;
            end
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.seg_out, bus.an_n, bus.frame_done} !== {e.seg, e.an, e.done}) begin
                    errors++;
                    $display("FAIL out @%0t: seg=%b an=%b done=%b, required seg=%b an=%b done=%b",
                             $time, bus.seg_out, bus.an_n, bus.frame_done, e.seg, e.an, e.done);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge just before the edge that samples frame position t
    task automatic wait_p(input int t);
        for (int i = 0; i < 2 * FR; i++) begin
            if (p % FR == t) return;
            @(negedge clk);
        end
        errors++;
        $display("FAIL wait_p: position %0d not reached, required within %0d cycles", t, 2 * FR);
    endtask

    task automatic do_load(input logic [0:6] a, input logic [0:6] b, input logic [0:6] c);
        bus.load    = 1'b1;
        bus.seg0_in = a;
        bus.seg1_in = b;
        bus.seg2_in = c;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.load    = 1'b0;
        bus.blank   = 1'b0;
        bus.seg0_in = '1;
        bus.seg1_in = '1;
        bus.seg2_in = '1;
`ifdef SEG_SCAN_BLINK_EN
        bus.blink   = 1'b0;
`endif
        #1 rst_n = 1'b0;
        cyc(5);
        rst_n = 1'b1;

        // Load while digit 1 is scanned: current frame stays blank
        wait_p(10);
        do_load(7'b0001000, 7'b0000000, 7'b0111000);
        cyc(2 * FR);

        // Two loads in one frame, then a third exactly on the boundary cycle
        wait_p(2);
        do_load(7'b1001111, 7'b0010010, 7'b0000110);
        cyc(3);
        do_load(7'b1001100, 7'b0100100, 7'b0100000);
        wait_p(FR - 1);
        do_load(7'b0001111, 7'b0000100, 7'b1000010);
        cyc(3 * FR);

        // Blank pulse of three cycles mid-slot
        wait_p(12);
        bus.blank = 1'b1;
        cyc(3);
        bus.blank = 1'b0;
        cyc(FR);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.blank   = ($urandom_range(0, 9) == 0);
            bus.load    = ($urandom_range(0, 7) == 0);
            bus.seg0_in = 7'($urandom);
            bus.seg1_in = 7'($urandom);
            bus.seg2_in = 7'($urandom);
            @(negedge clk);
        end
        bus.blank = 1'b0;
        bus.load  = 1'b0;
        cyc(2 * FR);

        // Asynchronous reset while digit 2 is scanned, with a load pending
        wait_p(18);
        do_load(7'b0110000, 7'b0110000, 7'b0110000);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.seg_out, bus.an_n, bus.frame_done} !== {7'h7f, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: seg=%b an=%b done=%b, required 1111111 111 0",
                     bus.seg_out, bus.an_n, bus.frame_done);
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(2 * FR);
        wait_p(5);
        do_load(7'b1000000, 7'b1111001, 7'b0100100);
        cyc(2 * FR);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
